// File: rtl/dtcm_responder_if.sv
// Load/store link between the LSU (master) and the data TCM responder (slave).
// Handshake: a transfer happens on a rising clk edge where valid && ready; the sender
// holds valid and its payload stable until that edge, and valid never waits on ready.
interface dtcm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_sign_extend;
  logic [1:0]  req_data_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_sign_extend, req_data_width, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_sign_extend, req_data_width, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dtcm_responder.sv
// Data TCM responder: one byte/half/word access at a time on an internal word RAM.
// Define DTCM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of aligning them.
module dtcm_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  dtcm_responder_if.slave  bus,
  output logic [1:0]       state_dbg
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Exclusive end of the window, kept 33 bits wide so the top of the 32-bit space cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        lat_we;
  logic        lat_se;
  logic [1:0]  lat_width;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] eff_addr;
  logic        misalign;
  logic        in_window;
  logic        acc_err;
  logic [31:0] offset;
  logic [AW-1:0] ram_idx;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_q;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- state register and request capture ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_se    <= 1'b0;
      lat_width <= W_BYTE;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_se    <= bus.req_sign_extend;
        lat_width <= bus.req_data_width;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.req_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign state_dbg = state;

  // ---------------- address decode and error detection ----------------
`ifdef DTCM_MISALIGN_ERR_EN
  always_comb begin
    eff_addr = lat_addr;
    misalign = ((lat_width == W_HALF) && lat_addr[0]) ||
               ((lat_width == W_WORD) && (lat_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    eff_addr = lat_addr;
    misalign = 1'b0;
    case (lat_width)
      W_HALF:  eff_addr = {lat_addr[31:1], 1'b0};
      W_WORD:  eff_addr = {lat_addr[31:2], 2'b00};
      default: eff_addr = lat_addr;
    endcase
  end
`endif

  always_comb begin
    in_window = ({1'b0, eff_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, eff_addr} < WIN_END);
    acc_err   = (lat_width == W_RSVD) || !in_window || misalign;
    offset    = eff_addr - BASE_ADDR;
    ram_idx   = AW'(offset >> 2);
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    be = 4'b0000;
    wd = lat_wdata;
    case (lat_width)
      W_BYTE: begin
        be = 4'b0001 << eff_addr[1:0];
        wd = {4{lat_wdata[7:0]}};
      end
      W_HALF: begin
        be = eff_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{lat_wdata[15:0]}};
      end
      W_WORD: begin
        be = 4'b1111;
        wd = lat_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = lat_wdata;
      end
    endcase
  end

  // A reset arriving during ACCESS must not leave a write behind.
  assign ram_we = (state == ST_ACCESS) && lat_we && !acc_err && !rst;
  assign ram_re = (state == ST_ACCESS) && !lat_we && !acc_err && !rst;

  // ---------------- word RAM (contents not reset) ----------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_idx];
  end

  // ---------------- load formatting ----------------
  always_comb begin
    sel_byte  = 8'h00;
    sel_half  = 16'h0000;
    load_data = ram_q;
    case (eff_addr[1:0])
      2'd0:    sel_byte = ram_q[7:0];
      2'd1:    sel_byte = ram_q[15:8];
      2'd2:    sel_byte = ram_q[23:16];
      default: sel_byte = ram_q[31:24];
    endcase
    sel_half = eff_addr[1] ? ram_q[31:16] : ram_q[15:0];
    case (lat_width)
      W_BYTE:  load_data = lat_se ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      W_HALF:  load_data = lat_se ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
      default: load_data = ram_q;
    endcase
  end

  // Everything driven in RESP comes from capture registers or ram_q, so it holds under backpressure.
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_err   = (state == ST_RESP) && acc_err;
  assign bus.resp_rdata = ((state == ST_RESP) && !acc_err && !lat_we) ? load_data : 32'h0;

endmodule
